// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and default address.
package i2c_pkg;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'b0101010;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// Host-side byte interface of the I2C target, plus the FSM state for observation.
// rx_valid and tx_req are single-clk strobes with no back-pressure: rx_data is valid
// in the clk rx_valid is high; tx_data must be stable in the clk after tx_req.
interface i2c_slave_responder_if;
  import i2c_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       addressed;
  logic       busy;
  state_t     state;

  modport slave (
    output rx_data, rx_valid, tx_req, addressed, busy, state,
    input  tx_data
  );

  modport master (
    input  rx_data, rx_valid, tx_req, addressed, busy, state,
    output tx_data
  );

endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer with edge detection on the last two synchronized samples.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Reset to the idle bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_slave_responder.sv
// 7-bit-address I2C target: oversampled SCL/SDA, START/STOP detection, open-drain SDA,
// write bytes delivered on rx_data/rx_valid, read bytes fetched via tx_req/tx_data.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_scl,
  inout  wire                   i2c_sda,
  i2c_slave_responder_if.slave  host
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst(rst), .din(i2c_scl),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .rst(rst), .din(i2c_sda),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  // SCL must be high in both samples; an SDA edge coinciding with an SCL edge is data.
  assign start_det = sda_fall & scl_lvl & ~scl_rise;
  assign stop_det  = sda_rise & scl_lvl & ~scl_rise;

  state_t     state, state_d;
  logic [2:0] bit_cnt, cnt_d;
  logic [7:0] shreg, sh_d, shifted;
  logic       sda_low, sda_low_d;
  logic       ack_phase, phase_d;
  logic       rw, rw_d;
  logic       addressed, addressed_d;
  logic       busy, busy_d;
  logic [7:0] rx_data, rx_data_d;
  logic       rx_valid, rx_valid_d;
  logic       tx_req, tx_req_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd7;
      shreg     <= '0;
      sda_low   <= 1'b0;
      ack_phase <= 1'b0;
      rw        <= 1'b0;
      addressed <= 1'b0;
      busy      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= cnt_d;
      shreg     <= sh_d;
      sda_low   <= sda_low_d;
      ack_phase <= phase_d;
      rw        <= rw_d;
      addressed <= addressed_d;
      busy      <= busy_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      tx_req    <= tx_req_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = bit_cnt;
    sh_d        = shreg;
    sda_low_d   = sda_low;
    phase_d     = ack_phase;
    rw_d        = rw;
    addressed_d = addressed;
    busy_d      = busy;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    shifted     = {shreg[6:0], sda_lvl};

    if (stop_det) begin
      state_d     = IDLE;
      sda_low_d   = 1'b0;
      addressed_d = 1'b0;
      busy_d      = 1'b0;
    end else if (start_det) begin
      state_d     = ADDR;
      cnt_d       = 3'd7;
      sda_low_d   = 1'b0;
      addressed_d = 1'b0;
      busy_d      = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            sh_d  = shifted;
            cnt_d = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              if (shifted[7:1] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                rw_d    = shifted[0];
                phase_d = 1'b0;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              sda_low_d   = 1'b1;
              addressed_d = 1'b1;
              phase_d     = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              cnt_d     = 3'd7;
              state_d   = rw ? RD_DATA : WR_DATA;
              tx_req_d  = rw;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            sh_d  = shifted;
            cnt_d = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              rx_data_d  = shifted;
              rx_valid_d = 1'b1;
              state_d    = WR_ACK;
              phase_d    = 1'b0;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              sda_low_d = 1'b1;
              phase_d   = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              cnt_d     = 3'd7;
              state_d   = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          // The clk after tx_req loads the byte and puts its MSB on the bus.
          if (tx_req) begin
            sh_d      = host.tx_data;
            sda_low_d = ~host.tx_data[7];
            cnt_d     = 3'd7;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_low_d = 1'b0;
              state_d   = RD_ACK;
              phase_d   = 1'b0;
            end else begin
              sh_d      = {shreg[6:0], 1'b0};
              sda_low_d = ~shreg[6];
              cnt_d     = bit_cnt - 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_lvl) state_d = IGNORE;
            else         phase_d = 1'b1;
          end else if (scl_fall && ack_phase) begin
            tx_req_d = 1'b1;
            state_d  = RD_DATA;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign i2c_sda = sda_low ? 1'b0 : 1'bz;

  assign host.rx_data   = rx_data;
  assign host.rx_valid  = rx_valid;
  assign host.tx_req    = tx_req;
  assign host.addressed = addressed;
  assign host.busy      = busy;
  assign host.state     = state;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged I2C master drives the bus and a
// scoreboard checks received bytes, read bytes, ACK bits and host-side strobes.
module tb_i2c_slave_responder;
  import i2c_pkg::*;

  localparam int Q = 4;  // clks per quarter SCL period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_responder_if bus_if ();

  i2c_slave_responder #(.SLAVE_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .i2c_scl(scl),
    .i2c_sda(sda),
    .host   (bus_if)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];
  int tests = 0;
  int fails = 0;
  int rx_cnt = 0;
  int txreq_cnt = 0;
  bit seen_addr = 1'b0;
  bit both_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host-side monitor: rx scoreboard, tx byte feeder, strobe bookkeeping.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.rx_valid) begin
        rx_cnt++;
        if (exp_q.size() != 0) check("rx_data", 32'(bus_if.rx_data), 32'(exp_q.pop_front()));
      end
      if (bus_if.tx_req) begin
        txreq_cnt++;
        bus_if.tx_data = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hFF;
      end
      if (bus_if.rx_valid && bus_if.tx_req) both_seen = 1'b1;
      if (bus_if.addressed) seen_addr = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; tick(Q);
    scl = 1'b1;       tick(Q);
    m_sda_low = 1'b1; tick(Q);
    scl = 1'b0;       tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; tick(Q);
    scl = 1'b1;       tick(Q);
    m_sda_low = 1'b0; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; tick(Q);
    scl = 1'b1;     tick(2 * Q);
    scl = 1'b0;     tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; tick(Q);
    scl = 1'b1;       tick(Q);
    b = sda;          tick(Q);
    scl = 1'b0;       tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  // ack=1 drives ACK; nine returns SDA as seen on the 9th clock.
  task automatic read_byte(output logic [7:0] d, input logic ack, output logic nine);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    m_sda_low = ack; tick(Q);
    scl = 1'b1;      tick(Q);
    nine = sda;      tick(Q);
    scl = 1'b0;      tick(Q);
  endtask

  initial begin
    logic       ack;
    logic       nine;
    logic [7:0] d;
    int         base;

    // Reset state
    rst = 1'b1;
    tick(4);
    check("rst_rx_data", 32'(bus_if.rx_data), 32'h0);
    check("rst_rx_valid", 32'(bus_if.rx_valid), 32'h0);
    check("rst_tx_req", 32'(bus_if.tx_req), 32'h0);
    check("rst_addressed", 32'(bus_if.addressed), 32'h0);
    check("rst_busy", 32'(bus_if.busy), 32'h0);
    check("rst_state", 32'(bus_if.state), 32'(IDLE));
    check("rst_sda", 32'(sda), 32'h1);
    rst = 1'b0;
    tick(4);

    // Write 0xAB to own address
    base = rx_cnt;
    exp_q.push_back(8'hAB);
    i2c_start();
    check("wr_busy", 32'(bus_if.busy), 32'h1);
    write_byte(8'h54, ack);
    check("wr_addr_ack", 32'(ack), 32'h0);
    check("wr_addressed", 32'(bus_if.addressed), 32'h1);
    write_byte(8'hAB, ack);
    check("wr_data_ack", 32'(ack), 32'h0);
    i2c_stop();
    tick(4);
    check("wr_rx_count", 32'(rx_cnt - base), 32'd1);
    check("wr_rx_data_hold", 32'(bus_if.rx_data), 32'hAB);
    check("wr_busy_after_stop", 32'(bus_if.busy), 32'h0);
    check("wr_addressed_after_stop", 32'(bus_if.addressed), 32'h0);

    // Address mismatch
    base = rx_cnt;
    seen_addr = 1'b0;
    i2c_start();
    write_byte(8'h56, ack);
    check("mm_addr_nack", 32'(ack), 32'h1);
    write_byte(8'h55, ack);
    check("mm_data_nack", 32'(ack), 32'h1);
    check("mm_busy", 32'(bus_if.busy), 32'h1);
    i2c_stop();
    tick(4);
    check("mm_rx_count", 32'(rx_cnt - base), 32'd0);
    check("mm_never_addressed", 32'(seen_addr), 32'h0);

    // Single read of 0x5A with master NACK
    base = txreq_cnt;
    tx_q.push_back(8'h5A);
    rd_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'h55, ack);
    check("rd1_addr_ack", 32'(ack), 32'h0);
    read_byte(d, 1'b0, nine);
    check("rd1_byte", 32'(d), 32'(rd_q.pop_front()));
    check("rd1_nack_released", 32'(nine), 32'h1);
    tick(2);
    check("rd1_sda_released", 32'(sda), 32'h1);
    check("rd1_state_ignore", 32'(bus_if.state), 32'(IGNORE));
    i2c_stop();
    tick(4);
    check("rd1_tx_req_count", 32'(txreq_cnt - base), 32'd1);
    check("rd1_addressed_after_stop", 32'(bus_if.addressed), 32'h0);

    // Multi-byte read: 0xC3 (ACK), 0x0F (NACK)
    base = txreq_cnt;
    tx_q.push_back(8'hC3);
    tx_q.push_back(8'h0F);
    rd_q.push_back(8'hC3);
    rd_q.push_back(8'h0F);
    i2c_start();
    write_byte(8'h55, ack);
    check("rd2_addr_ack", 32'(ack), 32'h0);
    read_byte(d, 1'b1, nine);
    check("rd2_byte0", 32'(d), 32'(rd_q.pop_front()));
    read_byte(d, 1'b0, nine);
    check("rd2_byte1", 32'(d), 32'(rd_q.pop_front()));
    check("rd2_nack_released", 32'(nine), 32'h1);
    i2c_stop();
    tick(4);
    check("rd2_tx_req_count", 32'(txreq_cnt - base), 32'd2);

    // Repeated START after a partial byte
    base = rx_cnt;
    exp_q.push_back(8'h11);
    i2c_start();
    write_byte(8'h54, ack);
    check("rs_addr1_ack", 32'(ack), 32'h0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    i2c_start();
    check("rs_addressed_cleared", 32'(bus_if.addressed), 32'h0);
    check("rs_state_addr", 32'(bus_if.state), 32'(ADDR));
    write_byte(8'h54, ack);
    check("rs_addr2_ack", 32'(ack), 32'h0);
    write_byte(8'h11, ack);
    check("rs_data_ack", 32'(ack), 32'h0);
    i2c_stop();
    tick(4);
    check("rs_rx_count", 32'(rx_cnt - base), 32'd1);
    check("rs_rx_data", 32'(bus_if.rx_data), 32'h11);

    // Reset while the address ACK is driven
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h54 >> i));
    m_sda_low = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(1);
    check("rst_ack_driven", 32'(sda), 32'h0);
    rst = 1'b1;
    tick(1);
    check("rst_sda_released", 32'(sda), 32'h1);
    check("rst_mid_rx_data", 32'(bus_if.rx_data), 32'h0);
    check("rst_mid_addressed", 32'(bus_if.addressed), 32'h0);
    check("rst_mid_busy", 32'(bus_if.busy), 32'h0);
    check("rst_mid_state", 32'(bus_if.state), 32'(IDLE));
    rst = 1'b0;
    tick(Q);
    base = rx_cnt;
    exp_q.push_back(8'h77);
    i2c_start();
    write_byte(8'h54, ack);
    check("post_rst_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h77, ack);
    check("post_rst_data_ack", 32'(ack), 32'h0);
    i2c_stop();
    tick(4);
    check("post_rst_rx_count", 32'(rx_cnt - base), 32'd1);
    check("post_rst_rx_data", 32'(bus_if.rx_data), 32'h77);

    // Global properties
    check("rx_tx_strobe_overlap", 32'(both_seen), 32'h0);
    check("rx_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
